// File: rtl/rgb_stream_packer.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_stream_packer
//  Description : Packs one 24-bit {r,g,b} pixel per handshake into a dense
//                32-bit AXI4-Stream word stream (4 pixels -> 3 words, little
//                endian, b is the lowest byte). Start-of-frame goes out on
//                tuser and end-of-line on tlast. On end-of-line, a partial
//                word is flushed. Output words pass through a small FIFO
//                with a 2-wide write port.
//                Optional macro RGB_PACKER_ERR_EN adds a sticky err output.
//                err flags a partial line that a sof pixel discarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module rgb_stream_packer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    input  logic        valid,
    input  logic        sof,
    input  logic        eol,
    output logic        in_stream_ready,
    output logic [31:0] out_stream_tdata,
    output logic [3:0]  out_stream_tkeep,
    output logic        out_stream_tlast,
    output logic        out_stream_tuser,
    output logic        out_stream_tvalid,
    input  logic        out_stream_tready
`ifdef RGB_PACKER_ERR_EN
    ,
    output logic        err
`endif
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    // Packed FIFO entry layout: {user, last, keep[3:0], data[31:0]}
    logic [37:0]        r_mem_q [FIFO_DEPTH];

    logic [1:0]         r_res_q, w_res_d;
    logic [23:0]        r_res_data_q, w_res_data_d;
    logic               r_pend_user_q, w_pend_user_d;
    logic [c_PTR_W-1:0] r_wr_ptr_q, w_wr_ptr_d, r_rd_ptr_q, w_rd_ptr_d;
    logic [c_CNT_W-1:0] r_cnt_q, w_cnt_d;

    logic               w_accept;
    logic [1:0]         w_res_eff;
    logic [23:0]        w_res_data_eff;
    logic [47:0]        w_buf;
    logic               w_has_full;
    logic [1:0]         w_new_res;
    logic [23:0]        w_new_data;
    logic               w_flush;
    logic [3:0]         w_flush_keep;
    logic               w_pend_eff;
    logic               w_slot0_vld, w_slot1_vld;
    logic [37:0]        w_slot0, w_slot1;
    logic [1:0]         w_n_wr;
    logic               w_rd;
    logic [37:0]        w_head;

    assign w_accept        = valid && in_stream_ready;
    assign in_stream_ready = (r_cnt_q <= c_CNT_W'(FIFO_DEPTH - 2)) && !areset;

    // Pack the incoming pixel against the residue and build up to two FIFO words
    always_comb begin
        // A sof pixel starts from an empty residue; old bytes are dropped
        w_res_eff      = sof ? 2'd0 : r_res_q;
        w_res_data_eff = sof ? 24'd0 : r_res_data_q;
        w_buf          = ({24'd0, r, g, b} << {w_res_eff, 3'b000}) | {24'd0, w_res_data_eff};
        // res + 3 >= 4 exactly when there was at least one pending byte
        w_has_full     = (w_res_eff != 2'd0);
        if (w_has_full) begin
            w_new_res  = w_res_eff - 2'd1;
            w_new_data = {8'd0, w_buf[47:32]};
        end else begin
            w_new_res  = 2'd3;
            w_new_data = w_buf[23:0];
        end
        w_flush = eol && (w_new_res != 2'd0);
        case (w_new_res)
            2'd1:    w_flush_keep = 4'b0001;
            2'd2:    w_flush_keep = 4'b0011;
            2'd3:    w_flush_keep = 4'b0111;
            default: w_flush_keep = 4'b0000;
        endcase
        w_pend_eff = r_pend_user_q || sof;

        if (w_has_full) begin
            w_slot0 = {w_pend_eff, eol && !w_flush, 4'hF, w_buf[31:0]};
        end else begin
            w_slot0 = {w_pend_eff, 1'b1, w_flush_keep, 8'd0, w_new_data};
        end
        w_slot1     = {1'b0, 1'b1, w_flush_keep, 8'd0, w_new_data};
        w_slot0_vld = w_accept && (w_has_full || w_flush);
        w_slot1_vld = w_accept && w_has_full && w_flush;
        w_n_wr      = {1'b0, w_slot0_vld} + {1'b0, w_slot1_vld};

        w_res_d       = r_res_q;
        w_res_data_d  = r_res_data_q;
        w_pend_user_d = r_pend_user_q;
        if (w_accept) begin
            w_res_d       = w_flush ? 2'd0 : w_new_res;
            w_res_data_d  = w_flush ? 24'd0 : w_new_data;
            w_pend_user_d = w_slot0_vld ? 1'b0 : w_pend_eff;
        end
    end

    // FIFO pointer and occupancy bookkeeping (net change of writes and reads)
    always_comb begin
        w_rd       = out_stream_tvalid && out_stream_tready;
        w_wr_ptr_d = r_wr_ptr_q + c_PTR_W'(w_n_wr);
        w_rd_ptr_d = r_rd_ptr_q + c_PTR_W'(w_rd);
        w_cnt_d    = r_cnt_q + c_CNT_W'(w_n_wr) - c_CNT_W'(w_rd);
    end

    // Control state registers
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_res_q       <= 2'd0;
            r_res_data_q  <= 24'd0;
            r_pend_user_q <= 1'b0;
            r_wr_ptr_q    <= '0;
            r_rd_ptr_q    <= '0;
            r_cnt_q       <= '0;
        end else begin
            r_res_q       <= w_res_d;
            r_res_data_q  <= w_res_data_d;
            r_pend_user_q <= w_pend_user_d;
            r_wr_ptr_q    <= w_wr_ptr_d;
            r_rd_ptr_q    <= w_rd_ptr_d;
            r_cnt_q       <= w_cnt_d;
        end
    end

    // FIFO storage; the second slot goes one entry past the write pointer
    always_ff @(posedge aclk) begin
        if (w_slot0_vld) begin
            r_mem_q[r_wr_ptr_q] <= w_slot0;
        end
        if (w_slot1_vld) begin
            r_mem_q[r_wr_ptr_q + c_PTR_W'(1)] <= w_slot1;
        end
    end

    // Head of FIFO drives the output; outputs read zero while empty
    assign out_stream_tvalid = (r_cnt_q != '0);
    assign w_head            = out_stream_tvalid ? r_mem_q[r_rd_ptr_q] : 38'd0;
    assign out_stream_tdata  = w_head[31:0];
    assign out_stream_tkeep  = w_head[35:32];
    assign out_stream_tlast  = w_head[36];
    assign out_stream_tuser  = w_head[37];

`ifdef RGB_PACKER_ERR_EN
    logic r_err_q, w_err_d;

    // Sticky flag: a sof pixel discarded pending bytes of an unfinished line
    always_comb begin
        w_err_d = r_err_q || (w_accept && sof && (r_res_q != 2'd0));
    end

    // Error flag register
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_err_q <= 1'b0;
        end else begin
            r_err_q <= w_err_d;
        end
    end

    assign err = r_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rgb_stream_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rgb_stream_packer
//  Description : Directed self-checking bench for rgb_stream_packer.
//                Set RGB_PACKER_ERR_EN to also cover the err output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb_stream_packer;

    logic        aclk = 1'b0;
    logic        areset;
    logic [7:0]  r, g, b;
    logic        valid, sof, eol;
    logic        in_stream_ready;
    logic [31:0] out_stream_tdata;
    logic [3:0]  out_stream_tkeep;
    logic        out_stream_tlast;
    logic        out_stream_tuser;
    logic        out_stream_tvalid;
    logic        out_stream_tready;
`ifdef RGB_PACKER_ERR_EN
    logic        err;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    logic [37:0] q_words [$];   // {data, keep, last, user}
    logic [7:0]  exp_bytes [$];

    always #5 aclk = ~aclk;

    rgb_stream_packer #(.FIFO_DEPTH(4)) u_dut (
        .aclk              (aclk),
        .areset            (areset),
        .r                 (r),
        .g                 (g),
        .b                 (b),
        .valid             (valid),
        .sof               (sof),
        .eol               (eol),
        .in_stream_ready   (in_stream_ready),
        .out_stream_tdata  (out_stream_tdata),
        .out_stream_tkeep  (out_stream_tkeep),
        .out_stream_tlast  (out_stream_tlast),
        .out_stream_tuser  (out_stream_tuser),
        .out_stream_tvalid (out_stream_tvalid),
        .out_stream_tready (out_stream_tready)
`ifdef RGB_PACKER_ERR_EN
        ,
        .err               (err)
`endif
    );

    // Inputs change just after posedge, so a beat seen here transfers on the next edge
    always @(negedge aclk) begin
        if (!areset && out_stream_tvalid && out_stream_tready) begin
            q_words.push_back({out_stream_tdata, out_stream_tkeep, out_stream_tlast, out_stream_tuser});
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time observed 5000000 expected finish earlier");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [23:0] pix(input int i);
        return {8'(i), 8'(i * 7), 8'(i >> 2)};
    endfunction

    task automatic send(input logic [23:0] px, input logic s, input logic e);
        int waited = 0;
        {r, g, b} = px;
        sof   = s;
        eol   = e;
        valid = 1'b1;
        while (!in_stream_ready && waited < 200) begin
            tick();
            waited++;
        end
        if (!in_stream_ready) chk("send_timeout", 64'(in_stream_ready), 64'd1);
        tick();
        valid = 1'b0;
        sof   = 1'b0;
        eol   = 1'b0;
        exp_bytes.push_back(px[7:0]);
        exp_bytes.push_back(px[15:8]);
        exp_bytes.push_back(px[23:16]);
    endtask

    task automatic expect_word(input string tag, input logic [31:0] d, input logic [3:0] k,
                               input logic l, input logic u);
        int waited = 0;
        logic [37:0] w;
        while (q_words.size() == 0 && waited < 100) begin
            tick();
            waited++;
        end
        if (q_words.size() == 0) begin
            chk({tag, "_timeout"}, 64'(q_words.size()), 64'd1);
        end else begin
            w = q_words.pop_front();
            chk(tag, 64'(w), 64'({d, k, l, u}));
        end
    endtask

    // Expected full word taken from the independent byte-stream model
    task automatic exp_model(input string tag, input logic l, input logic u);
        logic [31:0] d;
        d = '0;
        for (int i = 0; i < 4; i++) begin
            if (exp_bytes.size() != 0) d[8*i +: 8] = exp_bytes.pop_front();
        end
        expect_word(tag, d, 4'hF, l, u);
    endtask

    initial begin
        int k;
        logic acc;
        logic [31:0] held;

        areset = 1'b1;
        valid = 1'b0; sof = 1'b0; eol = 1'b0;
        r = 8'd0; g = 8'd0; b = 8'd0;
        out_stream_tready = 1'b1;
        held = '0;
        repeat (3) tick();

        // Reset state
        chk("rst_ready",  64'(in_stream_ready),   64'd0);
        chk("rst_tvalid", 64'(out_stream_tvalid), 64'd0);
        chk("rst_tdata",  64'(out_stream_tdata),  64'd0);
        chk("rst_side",   64'({out_stream_tkeep, out_stream_tlast, out_stream_tuser}), 64'd0);
`ifdef RGB_PACKER_ERR_EN
        chk("rst_err", 64'(err), 64'd0);
`endif
        areset = 1'b0;
        tick();
        chk("ready_after_rst", 64'(in_stream_ready), 64'd1);

        // Four pixels -> three full words, tuser on the first
        send(24'h112233, 1'b1, 1'b0);
        send(24'h445566, 1'b0, 1'b0);
        send(24'h778899, 1'b0, 1'b0);
        send(24'hAABBCC, 1'b0, 1'b0);
        expect_word("t1_w0", 32'h66112233, 4'hF, 1'b0, 1'b1);
        expect_word("t1_w1", 32'h88994455, 4'hF, 1'b0, 1'b0);
        expect_word("t1_w2", 32'hAABBCC77, 4'hF, 1'b0, 1'b0);

        // eol on the second pixel: full word plus 2-byte flush; then res restarts at 0
        send(24'h112233, 1'b0, 1'b0);
        send(24'h445566, 1'b0, 1'b1);
        expect_word("t2_w0",    32'h66112233, 4'hF,    1'b0, 1'b0);
        expect_word("t2_flush", 32'h00004455, 4'b0011, 1'b1, 1'b0);
        send(24'hAABBCC, 1'b0, 1'b1);
        expect_word("t2_flush3", 32'h00AABBCC, 4'b0111, 1'b1, 1'b0);

        // Full 640-pixel line
        exp_bytes.delete();
        for (int i = 0; i < 640; i++) send(pix(i), i == 0, i == 639);
        for (int j = 0; j < 480; j++) exp_model($sformatf("line_w%0d", j), j == 479, j == 0);
        repeat (5) tick();
        chk("line_extra_words", 64'(q_words.size()), 64'd0);

        // Backpressure: sink stalls for 20 cycles while the source keeps offering
        exp_bytes.delete();
        out_stream_tready = 1'b0;
        k = 0;
        for (int c = 0; c < 20; c++) begin
            {r, g, b} = pix(1000 + k);
            valid = 1'b1;
            acc = in_stream_ready;
            if (acc) begin
                exp_bytes.push_back(pix(1000 + k)[7:0]);
                exp_bytes.push_back(pix(1000 + k)[15:8]);
                exp_bytes.push_back(pix(1000 + k)[23:16]);
            end
            if (c == 10) held = out_stream_tdata;
            tick();
            if (acc) k++;
        end
        valid = 1'b0;
        chk("bp_accepted",  64'(k),                 64'd4);
        chk("bp_ready_low", 64'(in_stream_ready),   64'd0);
        chk("bp_tvalid",    64'(out_stream_tvalid), 64'd1);
        chk("bp_stable",    64'(out_stream_tdata),  64'(held));
        chk("bp_no_xfer",   64'(q_words.size()),    64'd0);
        out_stream_tready = 1'b1;
        for (int i = 4; i < 8; i++) send(pix(1000 + i), 1'b0, i == 7);
        for (int j = 0; j < 6; j++) exp_model($sformatf("bp_w%0d", j), j == 5, 1'b0);

        // sof in the middle of packing discards the residue
        send(24'h010203, 1'b0, 1'b0);
        send(24'hDEADBE, 1'b1, 1'b0);
`ifdef RGB_PACKER_ERR_EN
        chk("sof_err", 64'(err), 64'd1);
`endif
        send(24'h0A0B0C, 1'b0, 1'b1);
        expect_word("sof_w0",    32'h0CDEADBE, 4'hF,    1'b0, 1'b1);
        expect_word("sof_flush", 32'h00000A0B, 4'b0011, 1'b1, 1'b0);

        // Reset with three words queued and res = 2
        out_stream_tready = 1'b0;
        send(24'h111111, 1'b0, 1'b0);
        send(24'h222222, 1'b0, 1'b1);
        send(24'h333333, 1'b0, 1'b0);
        send(24'h444444, 1'b0, 1'b0);
        chk("mr_queued", 64'(u_dut.r_cnt_q), 64'd3);
        areset = 1'b1;
        tick();
        chk("mr_tvalid", 64'(out_stream_tvalid), 64'd0);
        chk("mr_ready",  64'(in_stream_ready),   64'd0);
        chk("mr_tdata",  64'(out_stream_tdata),  64'd0);
`ifdef RGB_PACKER_ERR_EN
        chk("mr_err", 64'(err), 64'd0);
`endif
        areset = 1'b0;
        tick();
        chk("mr_ready_after", 64'(in_stream_ready), 64'd1);
        out_stream_tready = 1'b1;
        send(24'h556677, 1'b0, 1'b1);
        expect_word("mr_first", 32'h00556677, 4'b0111, 1'b1, 1'b0);
        repeat (3) tick();
        chk("mr_extra_words", 64'(q_words.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
